// File: rtl/mem_game_pkg.sv
// Shared types and helpers for the memory-game LED sequence player.
package mem_game_pkg;

    // Playback FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    // One bit of a one-hot LED decode. Colour indices at or above n_leds light nothing.
    function automatic logic onehot(input logic [31:0] sel,
                                    input logic [31:0] pos,
                                    input logic [31:0] n_leds);
        return (sel < n_leds) && (sel == pos);
    endfunction

endpackage

// File: rtl/led_sequence_player_phase_timer.sv
// Loadable down-counter used to time both the lit and the dark phase of each entry.
module phase_timer #(
    parameter int unsigned TICK_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    input  logic              en,
    output logic              zero
);

    logic [TICK_W-1:0] r_count;

    // Load has priority; otherwise count down and stop at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/led_sequence_player.sv
// Plays a stored colour sequence from the game's sequence RAM on a one-hot LED bank.
// Each entry is fetched, shown for ON_TICKS cycles, then followed by OFF_TICKS dark cycles.
module led_sequence_player
    import mem_game_pkg::*;
#(
    parameter int unsigned N_LEDS    = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned TICK_W    = 25,
    parameter int unsigned ON_TICKS  = 25000000,
    parameter int unsigned OFF_TICKS = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [SEL_W-1:0]  mem_data,
    output logic [N_LEDS-1:0] leds,
    output logic              busy,
    output logic              done
);

    localparam logic [TICK_W-1:0] ON_LOAD  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LOAD = TICK_W'(OFF_TICKS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_next;
    logic [N_LEDS-1:0]  r_leds;
    logic [N_LEDS-1:0]  w_led_bits;
    logic               r_busy;
    logic               r_done;
    logic               w_load;
    logic               w_en;
    logic               w_zero;
    logic [TICK_W-1:0]  w_load_val;
    logic               w_last;
    logic               w_accept;
    logic               w_advance;

    // Index compare is done at ADDR_W+1 bits so a full-depth sequence ends without wrapping
    assign w_last     = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_accept   = (r_state == ST_IDLE) && start && (length != '0);
    assign w_advance  = (r_state == ST_OFF) && w_zero && !w_last;
    assign w_sel_next = (r_state == ST_WAIT) ? mem_data : r_sel;

    phase_timer #(
        .TICK_W(TICK_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .zero     (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and phase timer control
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_en       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (length != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: w_next = ST_WAIT;
            ST_WAIT: begin
                w_next     = ST_ON;
                w_load     = 1'b1;
                w_load_val = ON_LOAD;
            end
            ST_ON: begin
                if (w_zero) begin
                    w_next     = ST_OFF;
                    w_load     = 1'b1;
                    w_load_val = OFF_LOAD;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_OFF: begin
                if (w_zero) begin
                    w_next = w_last ? ST_DONE : ST_FETCH;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // LED pattern for the colour that will be held during the coming cycle
    always_comb begin
        w_led_bits = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            w_led_bits[i] = onehot(32'(w_sel_next), i, N_LEDS);
        end
    end

    // Datapath registers; outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_sel      <= '0;
            r_leds     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len      <= length;
                r_idx      <= '0;
                r_mem_addr <= '0;
            end
            if (w_advance) begin
                r_idx      <= r_idx + 1'b1;
                r_mem_addr <= r_idx + 1'b1;
            end
            if (r_state == ST_WAIT) begin
                r_sel <= mem_data;
            end
            r_leds <= (w_next == ST_ON) ? w_led_bits : '0;
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE);
        end
    end

    assign mem_addr = r_mem_addr;
    assign leds     = r_leds;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
